// File: rtl/mem_stage_sequencer.sv
`timescale 1ns/1ps
// MEM-stage sequencer: freezes the pipeline around one held req/ack data-memory
// access, captures load data for MEM_WB, and halts on timeout/misalign/read+write.
module mem_stage_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead_Mem,
  input  logic        MemWrite_Mem,
  input  logic [31:0] ALUOUT_Mem,
  input  logic [31:0] WriteData_Mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadData_Mem,
  output logic        Stall_Pipe,
  output logic        Bubble_Wb,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             req_nx, we_nx, err_nx;
  logic [31:0]      addr_nx, wdata_nx, rdata_nx;
  logic [1:0]       code_nx;
  logic             op;

  assign op = MemRead_Mem | MemWrite_Mem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ReadData_Mem <= '0;
      err          <= 1'b0;
      err_code     <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      mem_req      <= req_nx;
      mem_we       <= we_nx;
      mem_addr     <= addr_nx;
      mem_wdata    <= wdata_nx;
      ReadData_Mem <= rdata_nx;
      err          <= err_nx;
      err_code     <= code_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    req_nx   = mem_req;
    we_nx    = mem_we;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    rdata_nx = ReadData_Mem;
    err_nx   = err;
    code_nx  = err_code;

    unique case (state)
      IDLE: begin
        if (op) begin
          if (MemRead_Mem && MemWrite_Mem) begin
            state_nx = ERR;
            err_nx   = 1'b1;
            code_nx  = 2'b11;
          end else if (ALUOUT_Mem[1:0] != 2'b00) begin
            state_nx = ERR;
            err_nx   = 1'b1;
            code_nx  = 2'b10;
          end else begin
            addr_nx  = ALUOUT_Mem;
            wdata_nx = WriteData_Mem;
            we_nx    = MemWrite_Mem;
            req_nx   = 1'b1;
            cnt_nx   = '0;
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        // ack is checked first so a completion on the last allowed cycle still succeeds
        if (mem_ack) begin
          req_nx   = 1'b0;
          if (!mem_we) rdata_nx = mem_rdata;
          state_nx = DONE;
        end else if (cnt == CNT_LAST) begin
          req_nx   = 1'b0;
          err_nx   = 1'b1;
          code_nx  = 2'b01;
          state_nx = ERR;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: state_nx = IDLE;
      ERR: begin
        state_nx = ERR;
        req_nx   = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Stall_Pipe = ((state == IDLE) && op) || (state == REQ) || (state == ERR);
    Bubble_Wb  = Stall_Pipe;
    busy       = (state != IDLE);
  end

endmodule

// File: doc/mem_stage_sequencer.md
Name: mem_stage_sequencer

Overview:
Sequences the MEM stage of the 5-stage pipeline against a variable-latency data memory using a req/ack handshake. On a load or store in MEM it freezes the upstream pipeline registers, issues one held memory request, captures load data for the MEM_WB register, and releases the pipeline. It zeroes the MEM_WB control bits while stalled, and detects timeout, misalignment and illegal read+write, halting the pipeline on any of them.

Parameters:
TIMEOUT, 16, max cycles spent in REQ without mem_ack before error (>=2)
CNT_W, 5, wait-counter width; must hold TIMEOUT

Ports:
clock  input  1  pipeline clock
reset  input  1  asynchronous, active-low reset
MemRead_Mem  input  1  load in MEM stage (from EX_MEM)
MemWrite_Mem  input  1  store in MEM stage (from EX_MEM)
ALUOUT_Mem  input  32  effective byte address
WriteData_Mem  input  32  store data
mem_req  output  1  request to data memory, registered
mem_we  output  1  1=write, 0=read; valid with mem_req
mem_addr  output  32  latched address; valid with mem_req
mem_wdata  output  32  latched store data; valid with mem_req
mem_ack  input  1  memory completion, one cycle per request
mem_rdata  input  32  read data, valid with mem_ack on a read
ReadData_Mem  output  32  captured load data to MEM_WB
Stall_Pipe  output  1  hold PC, IF_ID, ID_EX, EX_MEM
Bubble_Wb  output  1  force MEM_WB MemtoReg/RegWrite to 0 this edge
busy  output  1  state != IDLE
err  output  1  sticky error flag
err_code  output  2  01 timeout, 10 misaligned, 11 read+write; 00 none

Behaviour:
- Reset: asynchronous, active-low, clock is clock. State=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData_Mem=0, counter=0, err=0, err_code=00. Reset mid-request drops mem_req immediately; a late mem_ack is ignored.
- Combinational outputs:
  - op = MemRead_Mem|MemWrite_Mem.
  - Stall_Pipe = (IDLE & op) | REQ | ERR.
  - Bubble_Wb = Stall_Pipe.
  - busy = state!=IDLE.
- IDLE:
  - No op: stay; no stall.
  - Op with both read and write set: go to ERR, err_code=11, no request.
  - Op with ALUOUT_Mem[1:0]!=0: go to ERR, err_code=10, no request.
  - Otherwise:
    - Latch mem_addr=ALUOUT_Mem, mem_wdata=WriteData_Mem, mem_we=MemWrite_Mem.
    - Set mem_req=1, counter=0, go to REQ.
- REQ:
  - mem_req held 1; addr, data and we held stable.
  - counter increments each cycle.
  - On mem_ack:
    - mem_req=0.
    - If read, ReadData_Mem<=mem_rdata.
    - Go to DONE.
  - If counter==TIMEOUT-1 with no ack: mem_req=0, err_code=01, go to ERR.
  - Ack wins over timeout in the same cycle.
- DONE: exactly one cycle, no stall.
  - Pipeline advances; MEM_WB latches ReadData_Mem.
  - Always returns to IDLE; op is not re-evaluated in DONE.
  - Back-to-back memory ops are therefore separated by one DONE cycle.
- ERR: terminal until reset. err=1; Stall_Pipe=1; mem_req=0; mem_ack ignored.
- mem_ack outside REQ is ignored and produces no state change.
- Latency:
  - Detection cycle plus a zero-wait ack (ack in first REQ cycle) gives 2 stall cycles.
  - Each extra memory wait cycle adds one stall cycle.
- ReadData_Mem holds its last load value across stores and idle cycles.

Test Plan:
- Load, addr 0x0000_0010, ack in 1st REQ cycle with rdata 0xDEAD_BEEF → mem_req high 1 cycle, we=0, Stall_Pipe high 2 cycles, ReadData_Mem=0xDEADBEEF in DONE, Bubble_Wb low in DONE.
- Store, addr 0x20, data 0x1234_5678, ack after 3 wait cycles → mem_we=1, addr/data stable all 4 REQ cycles, stall 5 cycles, ReadData_Mem unchanged.
- No ack with TIMEOUT=16 → mem_req drops after 16 REQ cycles, err=1, err_code=01, Stall_Pipe stays 1; a later ack is ignored.
- Load to addr 0x0000_0013 → no mem_req, ERR with code 10; both MemRead and MemWrite set → ERR with code 11.
- Back-to-back loads (op held continuously) → DONE cycle between requests, two distinct captures, second address latched correctly.
- Reset asserted mid-REQ → mem_req, busy and Stall_Pipe low immediately, ReadData_Mem=0; after release, an ack arriving with no request is ignored and state stays IDLE.
